edge_event_monitor: RTL

- Parametrised, synthesizable multi-channel edge-sensitivity monitor. Each channel is independently configured to detect posedge, negedge, either edge, or nothing.
- Qualified events drive:
  - a shared toggle output;
  - per-channel hit strobes;
  - per-channel saturating event counters;
  - a saturating total-event counter.
- Sits beside coverage diagnostic stimulus as a clocked generalisation of a mixed-edge sensitivity list.

---
 rtl/edge_event_monitor.sv | 69 ++++++
 1 files changed

// File: rtl/edge_event_monitor.sv
// edge_event_monitor: per-channel edge qualification feeding hit strobes, a shared toggle and saturating counters
module edge_event_monitor #(
  parameter int CHANNELS = 3,
  parameter int CNT_W = 8,
  parameter int TOT_W = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       ev_in,
  input  logic [2*CHANNELS-1:0]     mode,
  output logic                      toggle,
  output logic [CHANNELS-1:0]       hit,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic [CHANNELS-1:0]       sat,
  output logic [TOT_W-1:0]          total
);
  localparam int SW = TOT_W + 5;
  logic [CHANNELS-1:0] prev_q, prev_d, hit_q, hit_d, sat_q, sat_d, rise, fall, q;
  logic [CHANNELS*CNT_W-1:0] count_q, count_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [SW-1:0] sum;
  logic toggle_q, toggle_d;
  always_comb begin
    logic [CNT_W-1:0] cur;
    rise = ev_in & ~prev_q;
    fall = ~ev_in & prev_q;
    prev_d = ev_in;
    q = '0;
    count_d = count_q;
    sat_d = sat_q;
    sum = {{(SW-TOT_W){1'b0}}, total_q};
    for (int i = 0; i < CHANNELS; i++) begin
      q[i] = enable & ((mode[2*i +: 2] == 2'b01 & rise[i]) |
                       (mode[2*i +: 2] == 2'b10 & fall[i]) |
                       (mode[2*i +: 2] == 2'b11 & (rise[i] | fall[i])));
      sum = sum + SW'(q[i]);
      cur = count_q[i*CNT_W +: CNT_W];
      count_d[i*CNT_W +: CNT_W] = clear ? '0 : cur + CNT_W'(q[i] & ~&cur);
      sat_d[i] = ~clear & (sat_q[i] | &count_d[i*CNT_W +: CNT_W]);
    end
    hit_d = q;
    toggle_d = toggle_q ^ |q;
    total_d = clear ? '0 : (|sum[SW-1:TOT_W]) ? '1 : sum[TOT_W-1:0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q   <= ev_in;
      hit_q    <= '0;
      sat_q    <= '0;
      count_q  <= '0;
      total_q  <= '0;
      toggle_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      hit_q    <= hit_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
      total_q  <= total_d;
      toggle_q <= toggle_d;
    end
  end
  assign toggle = toggle_q;
  assign hit = hit_q;
  assign count = count_q;
  assign sat = sat_q;
  assign total = total_q;
endmodule
